tbuf_bus_sequencer: RTL and testbench

Controls a shared tri-state bus built from `tbuf` drivers and receives on it. Arbitrates up to `N` requesters round-robin and drives complementary `EN`/`EN_BAR` pairs to each driver cell. Inserts break-before-make turnaround cycles between owners and captures the resolved bus value on the receive side. Sits between the per-driver `tbuf` cells and the bus consumer.

---
 rtl/tbuf_bus_sequencer.sv | 148 ++++++++++++++
 tb/tb_tbuf_bus_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tbuf_bus_sequencer.sv
// rtl/tbuf_bus_sequencer.sv - round-robin owner sequencer for a shared tri-state bus
// Registered EN/EN_BAR pairs with break-before-make turnaround and bus capture.
module tbuf_bus_sequencer #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [W-1:0]         BUS,
  output logic [N-1:0]         EN,
  output logic [N-1:0]         EN_BAR,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 BUSY,
  output logic                 RX_VALID,
  output logic [W-1:0]         RX_DATA,
  output logic [$clog2(N)-1:0] RX_SRC
);

  localparam int              IW     = $clog2(N);
  localparam logic [IW:0]     N_W    = (IW+1)'(N);
  localparam logic [3:0]      TURN_W = 4'(TURN);
  localparam logic [7:0]      MAXH_W = 8'(MAXHOLD);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  en_q, en_d, en_bar_q;
  logic [IW-1:0] gnt_q, gnt_d, last_q, last_d;
  logic [7:0]    hold_q, hold_d;
  logic [3:0]    turn_q, turn_d;
  logic          rx_valid_q;
  logic [W-1:0]  rx_data_q;
  logic [IW-1:0] rx_src_q;

  logic          pick_found;
  logic [IW-1:0] pick_id;
  logic [IW:0]   cand;
  logic          own_req, other_req;

  // Scan offsets from far to near so the nearest requester after LAST wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (REQ[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[IW-1:0];
      end
    end
  end

  assign own_req   = |(REQ & en_q);
  assign other_req = |(REQ & ~en_q);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      S_IDLE: begin
        en_d = '0;
        if (pick_found) begin
          state_d = S_OWN;
          en_d    = {{(N-1){1'b0}}, 1'b1} << pick_id;
          gnt_d   = pick_id;
          last_d  = pick_id;
          hold_d  = 8'd1;
        end
      end
      S_OWN: begin
        if (!own_req || (hold_q == MAXH_W && other_req)) begin
          state_d = S_TURN;
          en_d    = '0;
          turn_d  = TURN_W;
        end else if (hold_q != MAXH_W) begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_TURN: begin
        en_d = '0;
        if (turn_q <= 4'd1) begin
          if (pick_found) begin
            state_d = S_OWN;
            en_d    = {{(N-1){1'b0}}, 1'b1} << pick_id;
            gnt_d   = pick_id;
            last_d  = pick_id;
            hold_d  = 8'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = '0;
      end
    endcase
  end

  // EN_BAR gets its own flop so the pair never passes through a shared inverter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      en_bar_q   <= '1;
      gnt_q      <= '0;
      last_q     <= IW'(N-1);
      hold_q     <= '0;
      turn_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      en_bar_q   <= ~en_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      rx_valid_q <= |en_q;
      if (|en_q) begin
        rx_data_q <= BUS;
        rx_src_q  <= gnt_q;
      end
    end
  end

  assign EN       = en_q;
  assign EN_BAR   = en_bar_q;
  assign GNT_ID   = gnt_q;
  assign BUSY     = (state_q != S_IDLE);
  assign RX_VALID = rx_valid_q;
  assign RX_DATA  = rx_data_q;
  assign RX_SRC   = rx_src_q;

endmodule

// File: tb/tb_tbuf_bus_sequencer.sv
// tb/tb_tbuf_bus_sequencer.sv - scoreboard bench for tbuf_bus_sequencer
// Directed REQ/EN/BUSY table feeds expectation queues; a monitor pops and compares.
module tb_tbuf_bus_sequencer;
  localparam int N = 4, W = 8, TURN = 2, MAXHOLD = 3;

  logic         CLK;
  logic         RST;
  logic [N-1:0] REQ;
  logic [W-1:0] BUS;
  logic [N-1:0] EN, EN_BAR;
  logic [1:0]   GNT_ID, RX_SRC;
  logic         BUSY, RX_VALID;
  logic [W-1:0] RX_DATA;

  typedef struct packed { logic [3:0] req; logic [3:0] en; logic busy; } vec_t;
  typedef struct packed { logic [1:0] src; logic [7:0] data; } rx_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  rx_t  rx_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_on = 0;

  tbuf_bus_sequencer #(.N(N), .W(W), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .BUS(BUS), .EN(EN), .EN_BAR(EN_BAR),
    .GNT_ID(GNT_ID), .BUSY(BUSY), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_SRC(RX_SRC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic vr(input int n, input logic [3:0] req, input logic [3:0] en, input logic busy);
    repeat (n) vecs.push_back(vec_t'{req: req, en: en, busy: busy});
  endtask

  // Monitor: invariants every cycle, scoreboard pops while the directed table runs.
  initial begin
    logic [3:0] prev_en, inv;
    logic [1:0] exp_gnt;
    int         zero_run;
    bit         had_owner;
    vec_t       e;
    rx_t        r;
    prev_en = '0; exp_gnt = '0; zero_run = 0; had_owner = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        prev_en = '0; exp_gnt = '0; zero_run = 0; had_owner = 0;
        continue;
      end
      inv = ~EN;
      chk("en_bar_compl", {28'b0, EN_BAR}, {28'b0, inv});
      chk("en_onehot0", 32'($countones(EN) <= 1), 32'd1);
      if (EN != 0 && prev_en == 0 && had_owner)
        chk("turn_gap", 32'(zero_run >= TURN), 32'd1);
      if (EN != 0 && prev_en != 0)
        chk("owner_switch", {28'b0, EN}, {28'b0, prev_en});
      chk("rx_valid_vs_own", {31'b0, RX_VALID}, {31'b0, (prev_en != 0)});
      if (RX_VALID && prev_en != 0) begin
        chk("rx_data_bus", {24'b0, RX_DATA}, {24'b0, BUS});
        chk("rx_src_owner", {30'b0, RX_SRC}, {30'b0, oh2id(prev_en)});
      end
      if (sb_on) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_en", {28'b0, EN}, {28'b0, e.en});
          chk("sb_busy", {31'b0, BUSY}, {31'b0, e.busy});
          if (e.en != 0) exp_gnt = oh2id(e.en);
          chk("sb_gnt_id", {30'b0, GNT_ID}, {30'b0, exp_gnt});
        end
        if (RX_VALID) begin
          if (rx_q.size() == 0) begin
            chk("sb_rx_unexpected", 32'(rx_q.size()), 32'd1);
          end else begin
            r = rx_q.pop_front();
            chk("sb_rx_src", {30'b0, RX_SRC}, {30'b0, r.src});
            chk("sb_rx_data", {24'b0, RX_DATA}, {24'b0, r.data});
          end
        end
      end
      if (EN == 0) zero_run++;
      else begin zero_run = 0; had_owner = 1; end
      prev_en = EN;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    RST = 1'b1; REQ = '0; BUS = '0;
    repeat (2) @(negedge CLK);
    chk("rst_en", {28'b0, EN}, 32'h0);
    chk("rst_en_bar", {28'b0, EN_BAR}, 32'hF);
    chk("rst_gnt", {30'b0, GNT_ID}, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'h0);
    chk("rst_rx_valid", {31'b0, RX_VALID}, 32'h0);
    chk("rst_rx_data", {24'b0, RX_DATA}, 32'h0);
    chk("rst_rx_src", {30'b0, RX_SRC}, 32'h0);

    // Own driver 1 for two cycles, then hit reset between edges.
    RST = 1'b0; REQ = 4'b0010; BUS = 8'h3C;
    @(negedge CLK);
    chk("own1_en", {28'b0, EN}, 32'h2);
    chk("own1_en_bar", {28'b0, EN_BAR}, 32'hD);
    chk("own1_busy", {31'b0, BUSY}, 32'h1);
    chk("own1_gnt", {30'b0, GNT_ID}, 32'h1);
    @(negedge CLK);
    chk("own1_rx_valid", {31'b0, RX_VALID}, 32'h1);
    chk("own1_rx_data", {24'b0, RX_DATA}, 32'h3C);
    chk("own1_rx_src", {30'b0, RX_SRC}, 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("arst_en", {28'b0, EN}, 32'h0);
    chk("arst_en_bar", {28'b0, EN_BAR}, 32'hF);
    chk("arst_gnt", {30'b0, GNT_ID}, 32'h0);
    chk("arst_busy", {31'b0, BUSY}, 32'h0);
    chk("arst_rx_valid", {31'b0, RX_VALID}, 32'h0);
    chk("arst_rx_data", {24'b0, RX_DATA}, 32'h0);
    chk("arst_rx_src", {30'b0, RX_SRC}, 32'h0);
    REQ = '0;
    @(negedge CLK);
    RST = 1'b0;

    // Single requester: 3 owned cycles, TURN=2 dead cycles, back to idle.
    vr(3, 4'b0001, 4'b0001, 1); vr(2, 4'b0000, 4'b0000, 1); vr(2, 4'b0000, 4'b0000, 0);
    // All request: owners 1,2,3,0,1 each for MAXHOLD cycles, 2-cycle gaps.
    vr(3, 4'b1111, 4'b0010, 1); vr(2, 4'b1111, 4'b0000, 1);
    vr(3, 4'b1111, 4'b0100, 1); vr(2, 4'b1111, 4'b0000, 1);
    vr(3, 4'b1111, 4'b1000, 1); vr(2, 4'b1111, 4'b0000, 1);
    vr(3, 4'b1111, 4'b0001, 1); vr(2, 4'b1111, 4'b0000, 1);
    vr(3, 4'b1111, 4'b0010, 1); vr(2, 4'b0000, 4'b0000, 1); vr(1, 4'b0000, 4'b0000, 0);
    // Lone owner past MAXHOLD keeps the bus; late contender forces release at once.
    vr(12, 4'b0100, 4'b0100, 1); vr(2, 4'b0101, 4'b0000, 1); vr(1, 4'b0101, 4'b0001, 1);
    vr(2, 4'b0000, 4'b0000, 1); vr(1, 4'b0000, 4'b0000, 0);
    // Owner 1 drops while 2 waits; 2 preempted by 3; 3 drops on its grant edge.
    vr(1, 4'b0010, 4'b0010, 1); vr(1, 4'b0110, 4'b0010, 1); vr(2, 4'b0100, 4'b0000, 1);
    vr(1, 4'b0100, 4'b0100, 1); vr(2, 4'b1100, 4'b0100, 1); vr(1, 4'b1100, 4'b0000, 1);
    vr(1, 4'b1000, 4'b0000, 1); vr(2, 4'b0000, 4'b0000, 0);
    // Previous owner ranks last among simultaneous requesters.
    vr(3, 4'b0101, 4'b0001, 1); vr(2, 4'b0101, 4'b0000, 1); vr(1, 4'b0101, 4'b0100, 1);
    vr(2, 4'b0000, 4'b0000, 1); vr(2, 4'b0000, 4'b0000, 0);

    sb_on = 1;
    prev = '0;
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge CLK);
      REQ = vecs[k].req;
      BUS = 8'(k * 37 + 90);
      exp_q.push_back(vecs[k]);
      if (prev != 0) rx_q.push_back(rx_t'{src: oh2id(prev), data: BUS});
      prev = vecs[k].en;
    end
    repeat (3) @(negedge CLK);
    chk("sb_exp_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_rx_drained", 32'(rx_q.size()), 32'd0);
    sb_on = 0;

    // Random sticky requests; only the monitor invariants apply here.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      REQ = REQ ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      BUS = 8'($urandom);
    end
    REQ = '0;
    repeat (6) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
